// File: rtl/lcd_driver_pkg.sv
// Shared types and character constants for the alarm clock LCD front end.
// Optional ALARM_QUALIFY_EN build macro is consumed by lcd_driver.sv.
package lcd_driver_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] lcd_char_t;

    localparam lcd_char_t  ASCII_ZERO  = 8'h30;
    localparam lcd_char_t  ASCII_SPACE = 8'h20;
    localparam lcd_char_t  ASCII_E     = 8'h45;
    localparam bcd_digit_t BCD_MAX     = 4'd9;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/lcd_driver_if.sv
// Digit sources, display requests and registered LCD/alarm outputs of lcd_driver.
interface lcd_driver_if;
    import lcd_driver_pkg::*;

    bcd_digit_t key;
    bcd_digit_t alarm_time;
    bcd_digit_t current_time;
    logic [3:0] show_alarm;
    logic       show_new_time;
    lcd_char_t  display_time;
    logic       sound_alarm;

    modport master (
        output key, alarm_time, current_time, show_alarm, show_new_time,
        input  display_time, sound_alarm
    );

    modport slave (
        input  key, alarm_time, current_time, show_alarm, show_new_time,
        output display_time, sound_alarm
    );

endinterface

// File: rtl/lcd_digit_encoder.sv
// Combinational BCD digit to ASCII character encoder; non-BCD codes map to ERR_CHAR.
module lcd_digit_encoder
    import lcd_driver_pkg::*;
#(
    parameter lcd_char_t ERR_CHAR = ASCII_E
) (
    input  bcd_digit_t digit,
    output lcd_char_t  char_out
);

    always_comb begin
        char_out = ERR_CHAR;
        if (is_bcd(digit))
            char_out = ASCII_ZERO + {4'b0000, digit};
    end

endmodule

// File: rtl/lcd_driver.sv
// Selects key/alarm/current digit, encodes it for the LCD and raises the alarm on match.
// Build macro ALARM_QUALIFY_EN: suppress sound_alarm while a new time is being keyed in.
module lcd_driver
    import lcd_driver_pkg::*;
#(
    parameter lcd_char_t ERR_CHAR = ASCII_E,
    parameter lcd_char_t RST_CHAR = ASCII_SPACE
) (
    input  logic         clk,
    input  logic         reset,
    lcd_driver_if.slave  bus
);

    bcd_digit_t sel_digit;
    lcd_char_t  enc_char;
    logic [3:0] bit_match;
    logic       time_match;
    logic       sound_next;
    lcd_char_t  display_reg;
    logic       sound_reg;

    // Key entry wins over the alarm view, which wins over the running time.
    always_comb begin
        sel_digit = bus.current_time;
        if (bus.show_new_time)
            sel_digit = bus.key;
        else if (|bus.show_alarm)
            sel_digit = bus.alarm_time;
    end

    lcd_digit_encoder #(
        .ERR_CHAR (ERR_CHAR)
    ) u_encoder (
        .digit    (sel_digit),
        .char_out (enc_char)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cmp
            assign bit_match[gi] = ~(bus.current_time[gi] ^ bus.alarm_time[gi]);
        end
    endgenerate

    // Invalid digits never match, so a corrupted pair of equal codes stays silent.
    assign time_match = (&bit_match) && is_bcd(bus.current_time);

`ifdef ALARM_QUALIFY_EN
    assign sound_next = time_match && !bus.show_new_time;
`else
    assign sound_next = time_match;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            display_reg <= RST_CHAR;
            sound_reg   <= 1'b0;
        end else begin
            display_reg <= enc_char;
            sound_reg   <= sound_next;
        end
    end

    assign bus.display_time = display_reg;
    assign bus.sound_alarm  = sound_reg;

endmodule

// File: tb/tb_lcd_driver.sv
// Self-checking bench for lcd_driver: vector table, corner sequences, random vs. model.
module tb_lcd_driver;
    import lcd_driver_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    lcd_driver_if bus();

    lcd_driver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] key;
        logic [3:0] alm;
        logic [3:0] cur;
        logic [3:0] sa;
        logic       sn;
        logic [7:0] exp_d;
        logic       exp_s;
    } vec_t;

    vec_t vecs[13];

`ifdef ALARM_QUALIFY_EN
    localparam logic QUAL = 1'b1;
`else
    localparam logic QUAL = 1'b0;
`endif

    function automatic logic [7:0] model_char(input logic [3:0] d);
        if (int'(d) < 10) return 8'(48 + int'(d));
        return 8'h45;
    endfunction

    function automatic logic [7:0] model_disp(input logic rst, input logic [3:0] k,
            input logic [3:0] a, input logic [3:0] c, input logic [3:0] sa, input logic sn);
        if (rst) return 8'h20;
        if (sn) return model_char(k);
        if (sa != 4'd0) return model_char(a);
        return model_char(c);
    endfunction

    function automatic logic model_sound(input logic rst, input logic [3:0] a,
            input logic [3:0] c, input logic sn);
        if (rst) return 1'b0;
        if (QUAL && sn) return 1'b0;
        return (int'(c) == int'(a)) && (int'(c) < 10);
    endfunction

    task automatic drive(input logic rst, input logic [3:0] k, input logic [3:0] a,
            input logic [3:0] c, input logic [3:0] sa, input logic sn);
        reset             = rst;
        bus.key           = k;
        bus.alarm_time    = a;
        bus.current_time  = c;
        bus.show_alarm    = sa;
        bus.show_new_time = sn;
    endtask

    // Advance one edge, then sample away from it.
    task automatic step_check(input string name, input logic [7:0] exp_d, input logic exp_s);
        @(posedge clk);
        #1;
        checks++;
        if (bus.display_time !== exp_d) begin
            errors++;
            $display("FAIL %s display_time got %h expected %h", name, bus.display_time, exp_d);
        end
        checks++;
        if (bus.sound_alarm !== exp_s) begin
            errors++;
            $display("FAIL %s sound_alarm got %b expected %b", name, bus.sound_alarm, exp_s);
        end
        $display("%s: disp=%h exp=%h sound=%b exp=%b", name, bus.display_time, exp_d,
                 bus.sound_alarm, exp_s);
    endtask

    initial begin
        logic [3:0] rk, ra, rc, rsa;
        logic       rr, rsn;

        //         rst   key    alm    cur    sa     sn    disp   snd
        vecs[0]  = '{1'b0, 4'h0, 4'h0, 4'h3, 4'h0, 1'b0, 8'h33, 1'b0};
        vecs[1]  = '{1'b0, 4'h0, 4'h5, 4'h1, 4'hF, 1'b0, 8'h35, 1'b0};
        vecs[2]  = '{1'b0, 4'h0, 4'h5, 4'h1, 4'h1, 1'b0, 8'h35, 1'b0};
        vecs[3]  = '{1'b0, 4'h7, 4'h5, 4'h1, 4'hF, 1'b1, 8'h37, 1'b0};
        vecs[4]  = '{1'b0, 4'h0, 4'h5, 4'h5, 4'h0, 1'b0, 8'h35, 1'b1};
        vecs[5]  = '{1'b0, 4'h0, 4'h5, 4'h6, 4'h0, 1'b0, 8'h36, 1'b0};
        vecs[6]  = '{1'b0, 4'h0, 4'hA, 4'hA, 4'h0, 1'b0, 8'h45, 1'b0};
        vecs[7]  = '{1'b0, 4'hA, 4'h3, 4'h2, 4'h0, 1'b1, 8'h45, 1'b0};
        vecs[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h30, 1'b1};
        vecs[9]  = '{1'b0, 4'h0, 4'h9, 4'hF, 4'h2, 1'b0, 8'h39, 1'b0};
        vecs[10] = '{1'b1, 4'h1, 4'h5, 4'h5, 4'h0, 1'b0, 8'h20, 1'b0};
        vecs[11] = '{1'b0, 4'h0, 4'h9, 4'h9, 4'h8, 1'b0, 8'h39, 1'b1};
        vecs[12] = '{1'b0, 4'h0, 4'h7, 4'h4, 4'h0, 1'b1, 8'h30, 1'b0};

        // Reset held two cycles with arbitrary inputs, then first normal edge.
        drive(1'b1, 4'h9, 4'h2, 4'h2, 4'h3, 1'b1);
        step_check("reset_cycle0", 8'h20, 1'b0);
        drive(1'b1, 4'h4, 4'h8, 4'h8, 4'h0, 1'b0);
        step_check("reset_cycle1", 8'h20, 1'b0);
        drive(1'b0, 4'h4, 4'h2, 4'h2, 4'h0, 1'b0);
        step_check("reset_release", 8'h32, 1'b1);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rst, vecs[i].key, vecs[i].alm, vecs[i].cur, vecs[i].sa, vecs[i].sn);
            step_check($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_s);
        end

        // Time entry over a matching alarm, then entry ends.
        drive(1'b0, 4'hA, 4'h5, 4'h5, 4'h0, 1'b1);
        step_check("entry_match", 8'h45, !QUAL);
        step_check("entry_match_hold", 8'h45, !QUAL);
        drive(1'b0, 4'hA, 4'h5, 4'h5, 4'h0, 1'b0);
        step_check("entry_release", 8'h35, 1'b1);

        // Match followed by mismatch: alarm drops one cycle later.
        drive(1'b0, 4'h0, 4'h2, 4'h2, 4'h0, 1'b0);
        step_check("match_on", 8'h32, 1'b1);
        drive(1'b0, 4'h0, 4'h2, 4'h3, 4'h0, 1'b0);
        step_check("match_off", 8'h33, 1'b0);

        for (int n = 0; n < 400; n++) begin
            rr  = ($urandom_range(15) == 0);
            rk  = 4'($urandom_range(15));
            ra  = 4'($urandom_range(15));
            rc  = ($urandom_range(2) == 0) ? ra : 4'($urandom_range(15));
            rsa = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
            rsn = ($urandom_range(3) == 0);
            drive(rr, rk, ra, rc, rsa, rsn);
            step_check($sformatf("rand%0d", n), model_disp(rr, rk, ra, rc, rsa, rsn),
                       model_sound(rr, ra, rc, rsn));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
